dmem_lsu: RTL and testbench

- Load/store unit for the Gold processor memory stage; sits directly upstream of the 64-bit × 512 data memory and is its only driver.
- Accepts byte-addressed load/store requests from the pipeline over a valid/ready handshake.
- Performs sub-word stores by read-modify-write, because the memory has no byte enables.
- Returns extracted, right-aligned load data one response per load.

---
 rtl/dmem_lsu_if.sv | 44 ++++
 rtl/dmem_lsu.sv | 156 +++++++++++++++
 tb/tb_dmem_lsu.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Bus between the pipeline memory stage, the LSU and the 64-bit data memory.
// slave: the LSU side. master: the requester plus the memory.
// Macro LSU_LOAD_SEXT_EN adds the req_sext request field.
interface dmem_lsu_if #(
    parameter int AW = 9
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [0:1]    req_size;
    logic [0:AW+2] req_addr;
    logic [0:63]   req_wdata;
`ifdef LSU_LOAD_SEXT_EN
    logic          req_sext;
`endif
    logic          resp_valid;
    logic [0:63]   resp_rdata;
    logic          resp_err;
    logic          memEn;
    logic          memWrEn;
    logic [0:AW-1] memAddr;
    logic [0:63]   dataIn;
    logic [0:63]   dataOut;

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
`ifdef LSU_LOAD_SEXT_EN
        input  req_sext,
`endif
        input  dataOut,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output memEn, memWrEn, memAddr, dataIn
    );

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
`ifdef LSU_LOAD_SEXT_EN
        output req_sext,
`endif
        output dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  memEn, memWrEn, memAddr, dataIn
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of the 64-bit x 512 data memory.
// Sub-word stores are read-modify-write since the memory has no byte enables.
// Bit numbering is big-endian: bit 0 is the MSB, byte offset 0 is bits [0:7].
// Optional macro LSU_LOAD_SEXT_EN: per-load sign extension via req_sext.
module dmem_lsu #(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input logic clk,
    input logic reset,
    dmem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR} lsuState_t;

    lsuState_t      state;
    logic [0:AW-1]  hAddr;
    logic [0:1]     hSize;
    logic [0:2]     hOff;
    logic [0:DW-1]  hWdata;
    logic [0:DW-1]  merged;
    logic           hSext;

    logic [0:2]     reqOff;
    logic           aligned;
    logic [63:0]    laneMask;
    logic [5:0]     shamt;
    logic [63:0]    shifted;
    logic           signBit;
    logic [63:0]    loadData;
    logic [63:0]    mergeData;

    // Right-aligned mask covering one lane of the given size.
    function automatic logic [63:0] maskOf(input logic [1:0] size);
        case (size)
            2'b00:   maskOf = 64'h0000_0000_0000_00FF;
            2'b01:   maskOf = 64'h0000_0000_0000_FFFF;
            2'b10:   maskOf = 64'h0000_0000_FFFF_FFFF;
            default: maskOf = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Bit distance from the lane's LSB to the dword LSB. For an aligned
    // access the lane's last byte is off|(bytes-1), so 7 minus that is ~.
    function automatic logic [5:0] shiftOf(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] span;
        case (size)
            2'b00:   span = 3'd0;
            2'b01:   span = 3'd1;
            2'b10:   span = 3'd3;
            default: span = 3'd7;
        endcase
        shiftOf = {~(off | span), 3'b000};
    endfunction

    // Request alignment check.
    always_comb begin
        reqOff = bus.req_addr[AW:AW+2];
        case (bus.req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~reqOff[2];
            2'b10:   aligned = (reqOff[1:2] == 2'b00);
            default: aligned = (reqOff == 3'b000);
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        laneMask  = maskOf(hSize);
        shamt     = shiftOf(hSize, hOff);
        shifted   = bus.dataOut >> shamt;
        signBit   = |(shifted & laneMask & ~(laneMask >> 1));
        loadData  = shifted & laneMask;
        if (hSext && signBit)
            loadData = loadData | ~laneMask;
        mergeData = (bus.dataOut & ~(laneMask << shamt)) | ((hWdata & laneMask) << shamt);
    end

    // Memory port: straight from the request in IDLE, from held state in RMW_WR.
    always_comb begin
        bus.memEn   = 1'b0;
        bus.memWrEn = 1'b0;
        bus.memAddr = hAddr;
        bus.dataIn  = merged;
        if (!reset) begin
            case (state)
                IDLE: begin
                    bus.memAddr = bus.req_addr[0:AW-1];
                    bus.dataIn  = bus.req_wdata;
                    if (bus.req_valid) begin
                        bus.memEn   = aligned;
                        bus.memWrEn = bus.req_wr & (bus.req_size == 2'b11);
                    end
                end
                RMW_WR: begin
                    bus.memEn   = 1'b1;
                    bus.memWrEn = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) & ~reset;

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hAddr          <= '0;
            hSize          <= '0;
            hOff           <= '0;
            hWdata         <= '0;
            hSext          <= 1'b0;
            merged         <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!aligned) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (!(bus.req_wr && bus.req_size == 2'b11)) begin
                            // Sub-word store or any load: hold the request.
                            hAddr  <= bus.req_addr[0:AW-1];
                            hSize  <= bus.req_size;
                            hOff   <= reqOff;
                            hWdata <= bus.req_wdata;
`ifdef LSU_LOAD_SEXT_EN
                            hSext  <= bus.req_sext & ~bus.req_wr;
`else
                            hSext  <= 1'b0;
`endif
                            state  <= bus.req_wr ? RMW_RD : LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    bus.resp_rdata <= loadData;
                    bus.resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                RMW_RD: begin
                    merged <= mergeData;
                    state  <= RMW_WR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 64x512 memory model.
module tb_dmem_lsu;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dmem_lsu_if #(.AW(9)) bus ();
    dmem_lsu #(.DW(64), .AW(9)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [0:63] mem [0:511];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (bus.memEn && bus.memWrEn) mem[bus.memAddr] <= bus.dataIn;
        if (bus.memEn && !bus.memWrEn) bus.dataOut <= mem[bus.memAddr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input logic v, input logic wr, input logic [1:0] sz,
                          input logic [11:0] addr, input logic [63:0] wd, input logic sx);
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_size  = sz;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
`ifdef LSU_LOAD_SEXT_EN
        bus.req_sext  = sx;
`else
        if (sx) $display("note: req_sext ignored in this build");
`endif
    endtask

    logic [63:0] reqData [0:3];
    logic        reqWr   [0:3];
    logic [1:0]  reqSz   [0:3];
    logic [11:0] reqAd   [0:3];
    int          acc     [0:3];
    logic [63:0] resps   [0:3];
    int          idx;
    int          nresp;
    logic        accepted;

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        bus.dataOut = '0;
        reset = 1'b1;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        tick;
        // Reset state, with a request pending that must not reach memory
        check("rst_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        setReq(1'b1, 1'b1, 2'b11, 12'h010, 64'h1111, 1'b0);
        #1;
        check("rst_memEn", bus.memEn, 0);
        check("rst_memWrEn", bus.memWrEn, 0);
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 1);

        // Doubleword store then doubleword load at dword 2
        setReq(1'b1, 1'b1, 2'b11, 12'h010, 64'h0123456789ABCDEF, 1'b0);
        #1;
        check("dw_st_memEn", bus.memEn, 1);
        check("dw_st_memWrEn", bus.memWrEn, 1);
        check("dw_st_memAddr", bus.memAddr, 2);
        check("dw_st_dataIn", bus.dataIn, 64'h0123456789ABCDEF);
        tick;
        check("dw_st_ready", bus.req_ready, 1);
        check("dw_st_noresp", bus.resp_valid, 0);
        setReq(1'b1, 1'b0, 2'b11, 12'h010, 64'h0, 1'b0);
        #1;
        check("dw_ld_memEn", bus.memEn, 1);
        check("dw_ld_memWrEn", bus.memWrEn, 0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        #1;
        check("dw_ld_wait_ready", bus.req_ready, 0);
        check("dw_ld_wait_memEn", bus.memEn, 0);
        check("dw_ld_wait_resp", bus.resp_valid, 0);
        tick;
        check("dw_ld_resp_valid", bus.resp_valid, 1);
        check("dw_ld_resp_err", bus.resp_err, 0);
        check("dw_ld_rdata", bus.resp_rdata, 64'h0123456789ABCDEF);
        check("dw_ld_ready_back", bus.req_ready, 1);
        check("dw_mem2", mem[2], 64'h0123456789ABCDEF);

        // Byte store 0xAA at 0x013 -> read, merge, write
        setReq(1'b1, 1'b1, 2'b00, 12'h013, 64'hAA, 1'b0);
        #1;
        check("b_st_rd_memEn", bus.memEn, 1);
        check("b_st_rd_memWrEn", bus.memWrEn, 0);
        check("b_st_rd_memAddr", bus.memAddr, 2);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        #1;
        check("b_st_rmwrd_ready", bus.req_ready, 0);
        check("b_st_rmwrd_memEn", bus.memEn, 0);
        tick;
        check("b_st_rmwwr_ready", bus.req_ready, 0);
        check("b_st_wr_memEn", bus.memEn, 1);
        check("b_st_wr_memWrEn", bus.memWrEn, 1);
        check("b_st_wr_memAddr", bus.memAddr, 2);
        check("b_st_wr_dataIn", bus.dataIn, 64'h012345AA89ABCDEF);
        tick;
        check("b_st_ready_back", bus.req_ready, 1);
        check("b_st_mem2", mem[2], 64'h012345AA89ABCDEF);
        check("b_st_noresp", bus.resp_valid, 0);

        // Sub-word loads from 0x012345AA89ABCDEF
        setReq(1'b1, 1'b0, 2'b01, 12'h016, 64'h0, 1'b0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("h_ld_valid", bus.resp_valid, 1);
        check("h_ld_rdata", bus.resp_rdata, 64'h000000000000CDEF);
        setReq(1'b1, 1'b0, 2'b00, 12'h013, 64'h0, 1'b0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("b_ld_rdata", bus.resp_rdata, 64'h00000000000000AA);
        setReq(1'b1, 1'b0, 2'b10, 12'h014, 64'h0, 1'b0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("w_ld_rdata", bus.resp_rdata, 64'h0000000089ABCDEF);
`ifdef LSU_LOAD_SEXT_EN
        setReq(1'b1, 1'b0, 2'b01, 12'h016, 64'h0, 1'b1);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("h_ld_sext", bus.resp_rdata, 64'hFFFFFFFFFFFFCDEF);
        setReq(1'b1, 1'b0, 2'b00, 12'h012, 64'h0, 1'b1);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("b_ld_sext_pos", bus.resp_rdata, 64'h0000000000000045);
`endif

        // Misaligned word load at 0x012
        setReq(1'b1, 1'b0, 2'b10, 12'h012, 64'h0, 1'b0);
        #1;
        check("mis_ld_memEn", bus.memEn, 0);
        check("mis_ld_ready", bus.req_ready, 1);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        #1;
        check("mis_ld_valid", bus.resp_valid, 1);
        check("mis_ld_err", bus.resp_err, 1);
        check("mis_ld_rdata", bus.resp_rdata, 0);
        check("mis_ld_ready_after", bus.req_ready, 1);
        tick;
        check("mis_ld_valid_clr", bus.resp_valid, 0);
        check("mis_ld_err_clr", bus.resp_err, 0);

        // Misaligned half store: error, memory untouched
        setReq(1'b1, 1'b1, 2'b01, 12'h011, 64'h5555, 1'b0);
        #1;
        check("mis_st_memEn", bus.memEn, 0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        #1;
        check("mis_st_err", bus.resp_err, 1);
        check("mis_st_mem2", mem[2], 64'h012345AA89ABCDEF);
        tick;

        // Reset in RMW_WR aborts the byte store
        setReq(1'b1, 1'b1, 2'b00, 12'h010, 64'h55, 1'b0);
        tick;
        setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
        tick;
        check("abort_in_wr_memWrEn", bus.memWrEn, 1);
        reset = 1'b1;
        #1;
        check("abort_memEn", bus.memEn, 0);
        check("abort_ready", bus.req_ready, 0);
        tick;
        check("abort_mem2", mem[2], 64'h012345AA89ABCDEF);
        check("abort_ready_rst", bus.req_ready, 0);
        check("abort_resp", bus.resp_valid, 0);
        reset = 1'b0;
        #1;
        check("abort_ready_after", bus.req_ready, 1);
        tick;
        check("abort_resp_after", bus.resp_valid, 0);
        check("abort_mem2_after", mem[2], 64'h012345AA89ABCDEF);

        // Back-to-back with req_valid held high
        reqWr[0] = 1'b1; reqSz[0] = 2'b11; reqAd[0] = 12'h028; reqData[0] = 64'hFEDCBA9876543210;
        reqWr[1] = 1'b0; reqSz[1] = 2'b11; reqAd[1] = 12'h028; reqData[1] = 64'h0;
        reqWr[2] = 1'b1; reqSz[2] = 2'b00; reqAd[2] = 12'h02F; reqData[2] = 64'h11;
        reqWr[3] = 1'b0; reqSz[3] = 2'b10; reqAd[3] = 12'h02C; reqData[3] = 64'h0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = -1;
            resps[i] = '0;
        end
        idx = 0;
        nresp = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) setReq(1'b1, reqWr[idx], reqSz[idx], reqAd[idx], reqData[idx], 1'b0);
            else setReq(1'b0, 1'b0, 2'b00, 12'h000, 64'h0, 1'b0);
            #1;
            if (bus.resp_valid) begin
                if (nresp < 4) resps[nresp] = bus.resp_rdata;
                nresp++;
            end
            accepted = (idx < 4) && bus.req_ready;
            if (accepted) acc[idx] = c;
            tick;
            if (accepted) idx++;
        end
        check("b2b_acc0", 64'(acc[0]), 0);
        check("b2b_acc1", 64'(acc[1]), 1);
        check("b2b_acc2", 64'(acc[2]), 3);
        check("b2b_acc3", 64'(acc[3]), 6);
        check("b2b_nresp", 64'(nresp), 2);
        check("b2b_resp0", resps[0], 64'hFEDCBA9876543210);
        check("b2b_resp1", resps[1], 64'h0000000076543211);
        check("b2b_mem5", mem[5], 64'hFEDCBA9876543211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
